mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 209 ++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// Back end of a five-stage RISC pipeline. It holds the EX/MEM and MEM/WB
// pipeline registers, a word-addressed data memory, and the write-back mux
// that feeds the register file.
//
// Timing: an instruction presented on the EX-side inputs is captured into
// EX/MEM at edge 1. It accesses data memory during the following cycle and is
// captured into MEM/WB at edge 2. WBData is therefore valid two rising edges
// after issue, plus one edge for every stalled cycle.
//
// Parameters
//   DMEM_DEPTH       number of 32-bit data-memory words (power of two, 4..4096)
//
// Optional feature (compile-time macro)
//   MEM_ALIGN_CHECK_EN  when defined, a memory access whose address has
//                       ALUResult[1:0] != 0 is suppressed. A load returns 0,
//                       a store does not write, and MisalignErr latches high
//                       until reset. When undefined, the low address bits are
//                       ignored and MisalignErr is tied to 0.
//
// Ports
//   clk              single clock; all state changes on its rising edge
//   reset            asynchronous, active-high; clears both pipeline registers
//   Stall            holds both pipeline registers and blocks memory writes
//   Flush            loads a bubble into EX/MEM (has priority over Stall there)
//   ALUResult        EX result: memory byte address or ALU result
//   StoreData        store operand
//   WriteReg         destination register number
//   RegWrite, MemRead, MemWrite, MemToReg   EX-stage control bits
//   EXMEM_RegWrite, EXMEM_WriteReg, EXMEM_ALUResult  forwarding taps (EX/MEM)
//   MEMWB_RegWrite, MEMWB_WriteReg, WBData           register-file write port
//   MisalignErr      sticky misaligned-access flag
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [31:0] ALUResult,
    input  logic [31:0] StoreData,
    input  logic [4:0]  WriteReg,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemToReg,
    output logic        EXMEM_RegWrite,
    output logic [4:0]  EXMEM_WriteReg,
    output logic [31:0] EXMEM_ALUResult,
    output logic        MEMWB_RegWrite,
    output logic [4:0]  MEMWB_WriteReg,
    output logic [31:0] WBData,
    output logic        MisalignErr
);

    // Width of the word index into data memory.
    localparam int AW = $clog2(DMEM_DEPTH);

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [4:0]  write_reg;
        logic [31:0] alu_result;
        logic [31:0] store_data;
    } exmem_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  write_reg;
        logic [31:0] alu_result;
        logic [31:0] read_data;
    } memwb_t;

    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    logic [31:0] dmem [DMEM_DEPTH];
    logic [AW-1:0] mem_idx;
    logic [31:0] mem_rdata;
    logic [31:0] read_data;
    logic        misalign;
    logic        mem_we;

    // ------------------------------------------------------------------
    // EX/MEM next state
    // ------------------------------------------------------------------
    // NOTE: every signal driven from always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        exmem_d = exmem_q;
        if (Flush) begin
            // Bubble: all control bits cleared. The data fields do not matter,
            // but clearing them keeps the forwarding taps quiet.
            exmem_d = '0;
        end else if (!Stall) begin
            // A write to register 0 is squashed here so it never reaches the
            // forwarding unit or the register file.
            exmem_d.reg_write  = RegWrite && (WriteReg != 5'd0);
            exmem_d.mem_read   = MemRead;
            exmem_d.mem_write  = MemWrite;
            exmem_d.mem_to_reg = MemToReg;
            exmem_d.write_reg  = WriteReg;
            exmem_d.alu_result = ALUResult;
            exmem_d.store_data = StoreData;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments, so
    // every register samples the values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    // Address bits above the index are dropped, so accesses wrap modulo
    // 4*DMEM_DEPTH bytes.
    assign mem_idx   = exmem_q.alu_result[AW+1:2];
    assign mem_rdata = dmem[mem_idx];

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q;

    assign misalign = (exmem_q.mem_read || exmem_q.mem_write)
                      && (exmem_q.alu_result[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (misalign) begin
            err_q <= 1'b1;
        end
    end

    assign MisalignErr = err_q;
`else
    assign misalign    = 1'b0;
    assign MisalignErr = 1'b0;
`endif

    // The read happens before the write in the same cycle, so a combined
    // read/write entry returns the old word.
    assign read_data = misalign ? 32'h0 : mem_rdata;

    // Gating with reset kills a store whose edge coincides with reset.
    assign mem_we = exmem_q.mem_write && !Stall && !misalign && !reset;

    // NOTE: the data memory is deliberately not reset. Its contents survive
    // reset, and a plain clocked block lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            dmem[mem_idx] <= exmem_q.store_data;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB
    // ------------------------------------------------------------------
    // Stall freezes MEM/WB even when Flush is also asserted.
    always_comb begin
        memwb_d = memwb_q;
        if (!Stall) begin
            memwb_d.reg_write  = exmem_q.reg_write;
            memwb_d.mem_to_reg = exmem_q.mem_to_reg;
            memwb_d.write_reg  = exmem_q.write_reg;
            memwb_d.alu_result = exmem_q.alu_result;
            memwb_d.read_data  = read_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memwb_q <= '0;
        end else begin
            memwb_q <= memwb_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign EXMEM_RegWrite  = exmem_q.reg_write;
    assign EXMEM_WriteReg  = exmem_q.write_reg;
    assign EXMEM_ALUResult = exmem_q.alu_result;

    assign MEMWB_RegWrite  = memwb_q.reg_write;
    assign MEMWB_WriteReg  = memwb_q.write_reg;
    assign WBData          = memwb_q.mem_to_reg ? memwb_q.read_data
                                                : memwb_q.alu_result;

    // Address bits outside the word index are unused in some builds, and
    // mem_read only matters to the alignment check.
    logic unused_bits;
    assign unused_bits = ^{exmem_q.mem_read,
                           exmem_q.alu_result[31:AW+2],
                           exmem_q.alu_result[1:0]};

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Scoreboard bench for mem_wb_stage. Each issued instruction pushes its
// expected EX/MEM taps and write-back result onto a queue. The expected
// memory read data comes from a reference memory that is updated in program
// order. When an instruction reaches MEM/WB, its entry is popped from the
// queue and compared with the outputs.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall, Flush;
    logic [31:0] ALUResult, StoreData;
    logic [4:0]  WriteReg;
    logic        RegWrite, MemRead, MemWrite, MemToReg;
    logic        EXMEM_RegWrite;
    logic [4:0]  EXMEM_WriteReg;
    logic [31:0] EXMEM_ALUResult;
    logic        MEMWB_RegWrite;
    logic [4:0]  MEMWB_WriteReg;
    logic [31:0] WBData;
    logic        MisalignErr;

    always #5 clk = ~clk;

    mem_wb_stage #(.DMEM_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .Stall           (Stall),
        .Flush           (Flush),
        .ALUResult       (ALUResult),
        .StoreData       (StoreData),
        .WriteReg        (WriteReg),
        .RegWrite        (RegWrite),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .MemToReg        (MemToReg),
        .EXMEM_RegWrite  (EXMEM_RegWrite),
        .EXMEM_WriteReg  (EXMEM_WriteReg),
        .EXMEM_ALUResult (EXMEM_ALUResult),
        .MEMWB_RegWrite  (MEMWB_RegWrite),
        .MEMWB_WriteReg  (MEMWB_WriteReg),
        .WBData          (WBData),
        .MisalignErr     (MisalignErr)
    );

    typedef struct packed {
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] sd;
    } instr_t;

    typedef struct packed {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] wb;
    } exp_t;

    exp_t        sb[$];
    exp_t        hold;
    logic [31:0] ref_mem [int];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic instr_t mk_r(input logic [31:0] v, input logic [4:0] wr);
        instr_t i = '0;
        i.rw = 1'b1; i.wr = wr; i.alu = v;
        return i;
    endfunction

    function automatic instr_t mk_ld(input logic [31:0] a, input logic [4:0] wr);
        instr_t i = '0;
        i.rw = 1'b1; i.mr = 1'b1; i.m2r = 1'b1; i.wr = wr; i.alu = a;
        return i;
    endfunction

    function automatic instr_t mk_st(input logic [31:0] a, input logic [31:0] d);
        instr_t i = '0;
        i.mw = 1'b1; i.alu = a; i.sd = d;
        return i;
    endfunction

    function automatic instr_t mk_junk();
        instr_t i;
        i.rw  = 1'b1; i.mr = 1'b1; i.mw = 1'b1; i.m2r = 1'b0;
        i.wr  = 5'($urandom_range(1, 31));
        i.alu = {$urandom} & 32'hFFFF_FFFC;
        i.sd  = $urandom;
        return i;
    endfunction

    task automatic drive(input instr_t i, input logic st, input logic fl);
        RegWrite  = i.rw;  MemRead  = i.mr;  MemWrite  = i.mw;
        MemToReg  = i.m2r; WriteReg = i.wr;  ALUResult = i.alu;
        StoreData = i.sd;  Stall    = st;    Flush     = fl;
    endtask

    task automatic check_exmem(input string tag, input exp_t e);
        check({tag, ".exmem_rw"},  32'(EXMEM_RegWrite), 32'(e.rw));
        check({tag, ".exmem_wr"},  32'(EXMEM_WriteReg), 32'(e.wr));
        check({tag, ".exmem_alu"}, EXMEM_ALUResult,     e.alu);
    endtask

    task automatic check_memwb(input string tag, input exp_t e);
        check({tag, ".memwb_rw"}, 32'(MEMWB_RegWrite), 32'(e.rw));
        check({tag, ".memwb_wr"}, 32'(MEMWB_WriteReg), 32'(e.wr));
        check({tag, ".wbdata"},   WBData,              e.wb);
    endtask

    // Issue one instruction with no stall and no flush. When apply is 0, a
    // store is left out of the reference memory because the bench knows it
    // will be killed before it commits.
    task automatic issue(input instr_t i, input bit apply, input string tag);
        exp_t        e;
        logic [31:0] rd;
        bit          mis;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (i.mr || i.mw) && (i.alu[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        rd = 32'h0;
        if (!mis && ref_mem.exists(widx(i.alu))) rd = ref_mem[widx(i.alu)];
        e.rw  = i.rw && (i.wr != 5'd0);
        e.wr  = i.wr;
        e.alu = i.alu;
        e.wb  = i.m2r ? rd : i.alu;
        if (i.mw && apply && !mis) ref_mem[widx(i.alu)] = i.sd;
        drive(i, 1'b0, 1'b0);
        sb.push_back(e);
        @(posedge clk); #1;
        hold = sb.pop_front();
        check_memwb(tag, hold);
        check_exmem(tag, sb[$]);
    endtask

    task automatic stall_n(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            drive(mk_junk(), 1'b1, 1'b0);
            @(posedge clk); #1;
            check_exmem(tag, sb[$]);
            check_memwb(tag, hold);
        end
    endtask

    task automatic flush_op(input logic st, input string tag);
        drive(mk_junk(), st, 1'b1);
        @(posedge clk); #1;
        if (st) begin
            // The pending EX/MEM entry is replaced by a bubble and MEM/WB holds.
            sb.delete(sb.size() - 1);
            sb.push_back('0);
            check_memwb(tag, hold);
        end else begin
            sb.push_back('0);
            hold = sb.pop_front();
            check_memwb(tag, hold);
        end
        check_exmem(tag, sb[$]);
    endtask

    task automatic check_all_zero(input string tag);
        check_exmem(tag, '0);
        check_memwb(tag, '0);
        check({tag, ".misalign"}, 32'(MisalignErr), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        drive('0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_all_zero({tag, ".async"});
        @(posedge clk); #1;
        check_all_zero({tag, ".held"});
        reset = 1'b0;
        sb.delete();
        sb.push_back('0);
        hold = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addrs [4];
        reset = 1'b0;
        drive('0, 1'b0, 1'b0);
        #2;
        do_reset("reset0");

        // Store, then an immediately following load of the same word.
        issue(mk_st(32'h10, 32'hDEADBEEF), 1'b1, "st10");
        issue(mk_ld(32'h10, 5'd8), 1'b1, "ld10");
        issue('0, 1'b1, "ld10_wb");
        check("ld10_wb.value", WBData, 32'hDEADBEEF);

        // Writes to register 0 never propagate.
        issue(mk_r(32'h5, 5'd0), 1'b1, "r0");
        issue(mk_r(32'h1234_5678, 5'd17), 1'b1, "r17");
        issue(mk_r(32'hFFFF_FFFF, 5'd31), 1'b1, "r31");

        // Address wrap: 0x400 and 0x000 map to the same word.
        issue(mk_st(32'h400, 32'hA5A5A5A5), 1'b1, "st400");
        issue(mk_ld(32'h000, 5'd4), 1'b1, "ld000");
        issue('0, 1'b1, "wrap_wb");

        // A combined read/write entry returns the pre-write data.
        issue(mk_st(32'h20, 32'h1111_1111), 1'b1, "st20");
        begin
            instr_t rmw = mk_ld(32'h20, 5'd9);
            rmw.mw = 1'b1;
            rmw.sd = 32'h2222_2222;
            issue(rmw, 1'b1, "rmw20");
        end
        issue(mk_ld(32'h20, 5'd10), 1'b1, "ld20");
        issue('0, 1'b1, "ld20_wb");

        // Load held by a three-cycle stall; its result appears 5 edges after issue.
        issue(mk_ld(32'h10, 5'd3), 1'b1, "ld_stall");
        stall_n(3, "stall3");
        issue('0, 1'b1, "stall_wb");
        check("stall_wb.value", WBData, 32'hDEADBEEF);

        // A stalled store commits once the stall is released.
        issue(mk_st(32'h30, 32'h3333), 1'b1, "st30");
        stall_n(2, "stall_st");
        issue(mk_ld(32'h30, 5'd12), 1'b1, "ld30");
        issue('0, 1'b1, "ld30_wb");

        // Flush together with Stall kills the pending store and holds MEM/WB.
        issue(mk_st(32'h40, 32'hCAFE), 1'b1, "st40");
        issue(mk_st(32'h40, 32'h1234), 1'b0, "st40_kill");
        flush_op(1'b1, "flush_stall");
        issue(mk_ld(32'h40, 5'd13), 1'b1, "ld40");
        issue('0, 1'b1, "ld40_wb");

        // Flush without Stall: the pending entry proceeds and the incoming one is dropped.
        issue(mk_r(32'h77, 5'd7), 1'b1, "r77");
        flush_op(1'b0, "flush");
        issue('0, 1'b1, "flush_wb");

        // Reset asserted while a store waits in EX/MEM suppresses that store.
        issue(mk_st(32'h50, 32'h600D), 1'b1, "st50");
        issue(mk_st(32'h50, 32'h0BAD), 1'b0, "st50_kill");
        do_reset("reset_mid");
        issue(mk_ld(32'h50, 5'd14), 1'b1, "ld50");
        issue('0, 1'b1, "ld50_wb");
        check("ld50_wb.value", WBData, 32'h600D);

        // Mixed random traffic over a few pre-written words.
        addrs[0] = 32'h200; addrs[1] = 32'h204; addrs[2] = 32'h2F8; addrs[3] = 32'h3FC;
        for (int k = 0; k < 4; k++) issue(mk_st(addrs[k], $urandom), 1'b1, "rnd_init");
        for (int k = 0; k < 24; k++) begin
            int kind = int'($urandom_range(0, 3));
            int a    = int'($urandom_range(0, 3));
            case (kind)
                0: issue(mk_r($urandom, 5'($urandom_range(0, 31))), 1'b1, "rnd_r");
                1: issue(mk_st(addrs[a], $urandom), 1'b1, "rnd_st");
                2: issue(mk_ld(addrs[a], 5'($urandom_range(1, 31))), 1'b1, "rnd_ld");
                default: stall_n(1, "rnd_stall");
            endcase
        end
        issue('0, 1'b1, "rnd_drain");

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned store is dropped and raises the sticky flag.
        issue(mk_st(32'h13, 32'h5555_5555), 1'b1, "st13");
        issue('0, 1'b1, "st13_b");
        check("misalign.set", 32'(MisalignErr), 32'h1);
        issue(mk_ld(32'h10, 5'd5), 1'b1, "ld10_after");
        issue(mk_ld(32'h12, 5'd6), 1'b1, "ld12_mis");
        issue('0, 1'b1, "mis_wb");
        check("misalign.sticky", 32'(MisalignErr), 32'h1);
        do_reset("reset_mis");
`else
        // Without the alignment check, the low address bits are ignored.
        issue(mk_st(32'h13, 32'h1313_1313), 1'b1, "st13");
        issue('0, 1'b1, "st13_b");
        check("misalign.tied", 32'(MisalignErr), 32'h0);
        issue(mk_ld(32'h10, 5'd5), 1'b1, "ld10_after");
        issue('0, 1'b1, "ld10_after_wb");
        check("ld10_after.value", WBData, 32'h1313_1313);
        do_reset("reset_end");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
